// File: rtl/vga_mon_pkg.sv
// Shared types and constants for the VGA timing monitor.
// Bit positions follow the Tiny VGA uo_out pinout.
package vga_mon_pkg;

  typedef enum logic [1:0] {
    SEARCH,
    MEASURE,
    LOCKED
  } state_t;

  localparam int HSYNC = 7;
  localparam int B0    = 6;
  localparam int G0    = 5;
  localparam int R0    = 4;
  localparam int VSYNC = 3;
  localparam int B1    = 2;
  localparam int G1    = 1;
  localparam int R1    = 0;

  localparam int E_HSW   = 0;
  localparam int E_LINE  = 1;
  localparam int E_VSW   = 2;
  localparam int E_FRAME = 3;
  localparam int E_BLANK = 4;
  localparam int ERR_W   = 5;

  function automatic int cnt_w(input int total);
    return $clog2(total + 1) + 1;
  endfunction

endpackage

// File: rtl/vga_timing_monitor_if.sv
// Bundle of the monitored VGA bus and the monitor's results.
// master drives the bus and observes; slave is the monitor side.
interface vga_timing_monitor_if
  import vga_mon_pkg::*;
;
  logic [7:0]       vga_in;
  logic             locked;
  logic             frame_done;
  logic [15:0]      frame_count;
  logic [15:0]      checksum;
  logic [ERR_W-1:0] err;

  modport master (
    output vga_in,
    input  locked, frame_done,
    input  frame_count, checksum, err
  );

  modport slave (
    input  vga_in,
    output locked, frame_done,
    output frame_count, checksum, err
  );
endinterface

// File: rtl/vga_sync_edge.sv
// Registers one sync bit, normalises polarity to 1 = asserted,
// and reports the registered level with its edges.
module vga_sync_edge #(
  parameter int ACTIVE_LOW = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sync,
  output logic level,
  output logic rise,
  output logic fall
);
  logic prev;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      level <= 1'b0;
      prev  <= 1'b0;
    end else begin
      level <= sync ^ (ACTIVE_LOW != 0);
      prev  <= level;
    end
  end

  assign rise = level & ~prev;
  assign fall = ~level & prev;
endmodule

// File: rtl/vga_timing_monitor.sv
// Passive timing checker and frame checksum for the Tiny VGA bus.
// All checks act on inputs registered once (one cycle of latency).
module vga_timing_monitor
  import vga_mon_pkg::*;
#(
  parameter int H_ACTIVE        = 640,
  parameter int H_FP            = 16,
  parameter int H_SYNC          = 96,
  parameter int H_BP            = 48,
  parameter int V_ACTIVE        = 480,
  parameter int V_FP            = 10,
  parameter int V_SYNC          = 2,
  parameter int V_BP            = 33,
  parameter int SYNC_ACTIVE_LOW = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       vga_in,
  output logic             locked,
  output logic             frame_done,
  output logic [15:0]      frame_count,
  output logic [15:0]      checksum,
  output logic [ERR_W-1:0] err
);
  localparam int H_TOTAL = H_FP + H_SYNC + H_BP + H_ACTIVE;
  localparam int V_TOTAL = V_FP + V_SYNC + V_BP + V_ACTIVE;
  localparam int HW = cnt_w(H_TOTAL);
  localparam int VW = cnt_w(V_TOTAL);

  localparam logic [HW-1:0] H_A0   = HW'(H_SYNC + H_BP);
  localparam logic [HW-1:0] H_A1   = HW'(H_SYNC + H_BP + H_ACTIVE - 1);
  localparam logic [HW-1:0] H_SW   = HW'(H_SYNC - 1);
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_A0   = VW'(V_SYNC + V_BP);
  localparam logic [VW-1:0] V_A1   = VW'(V_SYNC + V_BP + V_ACTIVE - 1);
  localparam logic [VW-1:0] V_SW   = VW'(V_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

  logic hs, hs_rise, hs_fall;
  logic vs, vs_rise, vs_fall;
  logic unused_vs_edges;

  vga_sync_edge #(.ACTIVE_LOW(SYNC_ACTIVE_LOW)) u_hs (
    .clk(clk), .rst_n(rst_n), .sync(vga_in[HSYNC]),
    .level(hs), .rise(hs_rise), .fall(hs_fall)
  );

  vga_sync_edge #(.ACTIVE_LOW(SYNC_ACTIVE_LOW)) u_vs (
    .clk(clk), .rst_n(rst_n), .sync(vga_in[VSYNC]),
    .level(vs), .rise(vs_rise), .fall(vs_fall)
  );

  // vsync is judged only at line starts, so its edges go unused
  assign unused_vs_edges = vs_rise | vs_fall | hs;

  state_t           state;
  logic [5:0]       rgb_q;
  logic [HW-1:0]    h_q, h_now;
  logic [VW-1:0]    v_q, v_now;
  logic             vs_smp, vs_wait, skip_line;
  logic [15:0]      acc;
  logic [ERR_W-1:0] e_now;
  logic             ls, fs, armed, pix_act;

  assign ls     = hs_rise;
  assign fs     = ls & vs & ~vs_smp;
  assign armed  = (state != SEARCH);
  assign locked = (state == LOCKED);

  always_comb begin
    h_now = (&h_q) ? h_q : h_q + 1'b1;
    if (ls) h_now = '0;
    v_now = v_q;
    if (fs)
      v_now = '0;
    else if (ls && !(&v_q))
      v_now = v_q + 1'b1;
    pix_act = (h_now >= H_A0) && (h_now <= H_A1) &&
              (v_now >= V_A0) && (v_now <= V_A1);
    e_now = '0;
    e_now[E_HSW]   = hs_fall && (h_q != H_SW);
    e_now[E_LINE]  = ls && !skip_line && (h_q != H_LAST);
    e_now[E_VSW]   = ls && vs_wait && !vs && (v_now != V_SW);
    e_now[E_FRAME] = fs && (v_q != V_LAST);
    e_now[E_BLANK] = (rgb_q != 6'd0) && !pix_act;
    if (!armed) e_now = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= SEARCH;
      rgb_q       <= '0;
      h_q         <= '0;
      v_q         <= '0;
      vs_smp      <= 1'b0;
      vs_wait     <= 1'b0;
      skip_line   <= 1'b0;
      acc         <= '0;
      frame_done  <= 1'b0;
      frame_count <= '0;
      checksum    <= '0;
      err         <= '0;
    end else begin
      rgb_q <= {vga_in[R1], vga_in[R0], vga_in[G1],
                vga_in[G0], vga_in[B1], vga_in[B0]};
      h_q        <= h_now;
      v_q        <= v_now;
      frame_done <= 1'b0;
      if (ls) vs_smp <= vs;
      if (fs)
        vs_wait <= 1'b1;
      else if (ls && !vs)
        vs_wait <= 1'b0;
      if (ls) skip_line <= 1'b0;
      if (fs)
        acc <= '0;
      else if (pix_act)
        acc <= {acc[14:0], acc[15]} ^ {10'b0, rgb_q};
      if (fs && armed) begin
        checksum    <= acc;
        frame_done  <= 1'b1;
        frame_count <= frame_count + 16'd1;
      end
      if (state == LOCKED) err <= err | e_now;
      // an error while measuring restarts the search silently
      unique case (state)
        SEARCH:
          if (fs) begin
            state     <= MEASURE;
            skip_line <= 1'b1;
          end
        MEASURE:
          if (|e_now)
            state <= SEARCH;
          else if (fs)
            state <= LOCKED;
        LOCKED:  state <= LOCKED;
        default: state <= SEARCH;
      endcase
    end
  end
endmodule

// File: tb/tb_vga_timing_monitor.sv
// Frame-level bench for vga_timing_monitor using a small 15x8 timing.
// Expected frame results are queued per frame and matched to frame_done.
module tb_vga_timing_monitor;

  localparam int HS_W = 3;
  localparam int HB_W = 2;
  localparam int HA_W = 8;
  localparam int HF_W = 2;
  localparam int VS_L = 2;

  typedef struct {
    int          pv;
    int          ph;
    logic [5:0]  prgb;
    int          lines;
    int          wide;
    int          rst_at;
    bit          push;
    bit          rst_before;
    bit          close_after;
    logic [15:0] cs;
    logic [15:0] cnt;
    logic [4:0]  er;
    int          period;
  } vec_t;

  typedef struct {
    logic [15:0] cs;
    logic [15:0] cnt;
    logic [4:0]  er;
    int          period;
  } exp_t;

  typedef struct {
    logic [15:0] cs;
    logic [15:0] cnt;
    logic [4:0]  er;
    logic        lk;
    int          cyc;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vga_timing_monitor_if vif();

  vga_timing_monitor #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .SYNC_ACTIVE_LOW(1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .vga_in(vif.vga_in),
    .locked(vif.locked),
    .frame_done(vif.frame_done),
    .frame_count(vif.frame_count),
    .checksum(vif.checksum),
    .err(vif.err)
  );

  int   n_tests = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   px_cyc = 0;
  int   err4_rise = -1;
  logic err4_prev = 1'b0;
  int   obs_rd = 0;
  exp_t exp_q[$];
  obs_t obs[$];
  vec_t tbl[16];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (vif.frame_done === 1'b1)
      obs.push_back('{vif.checksum, vif.frame_count,
                      vif.err, vif.locked, cyc});
    if (vif.err[4] === 1'b1 && !err4_prev) err4_rise = cyc;
    err4_prev = (vif.err[4] === 1'b1);
  end

  function automatic logic [7:0] enc(bit hs, bit vs, logic [5:0] c);
    return {~hs, c[0], c[2], c[4], ~vs, c[1], c[3], c[5]};
  endfunction

  function automatic logic [15:0] cs_model(int k, logic [5:0] v);
    logic [15:0] a;
    a = 16'h0;
    for (int i = 0; i < 32; i++)
      a = {a[14:0], a[15]} ^ ((i == k) ? {10'b0, v} : 16'h0);
    return a;
  endfunction

  function automatic vec_t mk(int pv, int ph, logic [5:0] prgb,
      int lines, int wide, int rst_at, bit push, bit rb, bit ca,
      logic [15:0] cs, logic [15:0] cnt, logic [4:0] er, int period);
    vec_t t;
    t.pv = pv; t.ph = ph; t.prgb = prgb;
    t.lines = lines; t.wide = wide; t.rst_at = rst_at;
    t.push = push; t.rst_before = rb; t.close_after = ca;
    t.cs = cs; t.cnt = cnt; t.er = er; t.period = period;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, ".locked"}, 32'(vif.locked), 0);
    chk({tag, ".frame_done"}, 32'(vif.frame_done), 0);
    chk({tag, ".frame_count"}, 32'(vif.frame_count), 0);
    chk({tag, ".checksum"}, 32'(vif.checksum), 0);
    chk({tag, ".err"}, 32'(vif.err), 0);
  endtask

  task automatic drain();
    exp_t e;
    while (obs_rd < obs.size()) begin
      if (exp_q.size() == 0) begin
        chk($sformatf("unexpected_frame_done@%0d", obs[obs_rd].cyc),
            32'(obs[obs_rd].cnt), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk($sformatf("checksum#%0d", e.cnt), 32'(obs[obs_rd].cs), 32'(e.cs));
        chk($sformatf("frame_count#%0d", e.cnt), 32'(obs[obs_rd].cnt), 32'(e.cnt));
        chk($sformatf("err#%0d", e.cnt), 32'(obs[obs_rd].er), 32'(e.er));
        chk($sformatf("locked#%0d", e.cnt), 32'(obs[obs_rd].lk), 1);
        if (e.period > 0 && obs_rd > 0)
          chk($sformatf("period#%0d", e.cnt),
              32'(obs[obs_rd].cyc - obs[obs_rd-1].cyc), 32'(e.period));
      end
      obs_rd++;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    vif.vga_in = enc(0, 0, 6'd0);
    repeat (3) @(negedge clk);
    chk_zero_outputs("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic drive_frame(input vec_t t);
    int idx;
    int hsw;
    logic [5:0] c;
    idx = 0;
    if (t.push) exp_q.push_back('{t.cs, t.cnt, t.er, t.period});
    for (int v = 0; v < t.lines; v++) begin
      hsw = (v == t.wide) ? 4 : HS_W;
      for (int col = 0; col < hsw + HB_W + HA_W + HF_W; col++) begin
        c = (v == t.pv && col == t.ph) ? t.prgb : 6'd0;
        if (c != 6'd0) px_cyc = cyc;
        if (idx == t.rst_at) rst_n = 1'b0;
        vif.vga_in = enc(col < hsw, v < VS_L, c);
        @(negedge clk);
        if (idx == t.rst_at) begin
          chk_zero_outputs("midframe_reset");
          rst_n = 1'b1;
        end
        idx++;
      end
    end
  endtask

  task automatic close_section();
    for (int col = 0; col < HS_W + HB_W + HA_W + HF_W; col++) begin
      vif.vga_in = enc(col < HS_W, 1, 6'd0);
      @(negedge clk);
    end
    vif.vga_in = enc(0, 0, 6'd0);
    repeat (3) @(negedge clk);
    drain();
    chk("scoreboard_empty", 32'(exp_q.size()), 0);
  endtask

  initial begin
    int rk;
    logic [5:0] rv;
    rk = int'($urandom_range(0, 31));
    rv = 6'($urandom_range(1, 63));
    tbl[0]  = mk(-1, -1, 6'd0, 8, -1, -1, 1, 1, 0, 16'h0000, 16'd1, 5'b00000, 0);
    tbl[1]  = mk(-1, -1, 6'd0, 8, -1, -1, 1, 0, 0, 16'h0000, 16'd2, 5'b00000, 120);
    tbl[2]  = mk(-1, -1, 6'd0, 8, -1, -1, 1, 0, 0, 16'h0000, 16'd3, 5'b00000, 120);
    tbl[3]  = mk(6, 12, 6'h3F, 8, -1, -1, 1, 0, 0, 16'h003F, 16'd4, 5'b00000, 120);
    tbl[4]  = mk(3, 5, 6'h3F, 8, -1, -1, 1, 0, 0, 16'h801F, 16'd5, 5'b00000, 120);
    tbl[5]  = mk(3 + rk / 8, 5 + rk % 8, rv, 8, -1, -1, 1, 0, 0,
                 cs_model(rk, rv), 16'd6, 5'b00000, 120);
    tbl[6]  = mk(-1, -1, 6'd0, 8, 1, -1, 1, 0, 1, 16'h0000, 16'd7, 5'b00011, 121);
    tbl[7]  = mk(-1, -1, 6'd0, 8, -1, -1, 1, 1, 0, 16'h0000, 16'd1, 5'b00000, 0);
    tbl[8]  = mk(-1, -1, 6'd0, 9, -1, -1, 1, 0, 0, 16'h0000, 16'd2, 5'b01000, 135);
    tbl[9]  = mk(-1, -1, 6'd0, 8, -1, -1, 1, 0, 1, 16'h0000, 16'd3, 5'b01000, 120);
    tbl[10] = mk(-1, -1, 6'd0, 8, -1, -1, 1, 1, 0, 16'h0000, 16'd1, 5'b00000, 0);
    tbl[11] = mk(3, 13, 6'b000010, 8, -1, -1, 1, 0, 1, 16'h0000, 16'd2, 5'b10000, 120);
    tbl[12] = mk(-1, -1, 6'd0, 8, -1, -1, 1, 1, 0, 16'h0000, 16'd1, 5'b00000, 0);
    tbl[13] = mk(-1, -1, 6'd0, 8, -1, -1, 1, 0, 0, 16'h0000, 16'd2, 5'b00000, 120);
    tbl[14] = mk(-1, -1, 6'd0, 8, -1, 67, 0, 0, 0, 16'h0000, 16'd0, 5'b00000, 0);
    tbl[15] = mk(-1, -1, 6'd0, 8, -1, -1, 1, 0, 1, 16'h0000, 16'd1, 5'b00000, 0);

    vif.vga_in = enc(0, 0, 6'd0);
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      if (tbl[i].rst_before) do_reset();
      drive_frame(tbl[i]);
      drain();
      if (i == 0 || i == 14 || i == 15)
        chk($sformatf("not_locked_yet#%0d", i), 32'(vif.locked), 0);
      if (i == 11) begin
        n_tests++;
        if (err4_rise < 0 || err4_rise - px_cyc < 1 || err4_rise - px_cyc > 2) begin
          n_fail++;
          $display("FAIL err4_latency: got %0d cycles expected 1..2",
                   err4_rise - px_cyc);
        end
      end
      if (tbl[i].close_after) close_section();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
